// File: rtl/conv_seq_ctrl.sv
// ---------------------------------------------------------------------------
// conv_seq_ctrl
// Sequencer for the 3x3 convolution engine. A frame starts with three kernel
// columns, followed by i_num_bands bands of i_num_cols image columns, all
// arriving on a valid/ready stream. Each group of columns is buffered first
// and then replayed to the engine as one gap-free burst. Every image burst is
// followed by three zero flush pushes. A window-result strobe is produced,
// tagged with band and column, aligned to the engine output.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   i_start         begin a frame (accepted only when idle)
//   i_num_cols      columns per band (3..MAX_COLS), sampled on accepted start
//   i_num_bands     bands per frame (>=1), sampled on accepted start
//   s_valid/s_data  upstream column stream {p2,p1,p0}
//   s_ready         upstream ready
//   eng_rst         engine clear
//   eng_valid       engine push
//   eng_sel_ki      0 = kernel push, 1 = image push
//   eng_d0/1/2      engine column data (zero while eng_valid is low)
//   o_res_valid     engine output holds a valid window result
//   o_res_band      band index of that result
//   o_res_col       window index within the band
//   o_busy          frame in progress
//   o_done          one-cycle pulse at frame completion
//   o_err           one-cycle pulse for a rejected start
// All outputs are registered.
// ---------------------------------------------------------------------------
module conv_seq_ctrl #(
    parameter int BIT_LEN  = 8,
    parameter int MAX_COLS = 64,
    parameter int COL_W    = 7,
    parameter int BAND_W   = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic [COL_W-1:0]       i_num_cols,
    input  logic [BAND_W-1:0]      i_num_bands,
    input  logic                   s_valid,
    input  logic [3*BIT_LEN-1:0]   s_data,
    output logic                   s_ready,
    output logic                   eng_rst,
    output logic                   eng_valid,
    output logic                   eng_sel_ki,
    output logic [BIT_LEN-1:0]     eng_d0,
    output logic [BIT_LEN-1:0]     eng_d1,
    output logic [BIT_LEN-1:0]     eng_d2,
    output logic                   o_res_valid,
    output logic [BAND_W-1:0]      o_res_band,
    output logic [COL_W-1:0]       o_res_col,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_err
);

    localparam int ADDR_W = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
    // Push index has to reach N+3 (flush pushes included).
    localparam int IDX_W  = COL_W + 1;

    localparam logic [COL_W-1:0]  COL_ONE  = COL_W'(1);
    localparam logic [COL_W-1:0]  MIN_C    = COL_W'(3);
    localparam logic [COL_W-1:0]  MAX_C    = COL_W'(MAX_COLS);
    localparam logic [BAND_W-1:0] BAND_ONE = BAND_W'(1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);

    typedef enum logic [2:0] {
        IDLE, K_FILL, K_PUSH, R_FILL, R_ALIGN, R_PUSH, R_FLUSH, DONE
    } state_t;

    state_t                 r_state;
    logic                   r_sReady;
    logic                   r_engRst;
    logic                   r_engValid;
    logic                   r_selKi;
    logic [3*BIT_LEN-1:0]   r_engData;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_err;
    logic [COL_W-1:0]       r_numCols;
    logic [BAND_W-1:0]      r_numBands;
    logic [BAND_W-1:0]      r_band;
    logic [COL_W-1:0]       r_wrIdx;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_parity;
    logic [3:0]             r_pipeValid;
    logic [BAND_W-1:0]      r_pipeBand [4];
    logic [COL_W-1:0]       r_pipeCol  [4];
    logic                   r_resValid;
    logic [BAND_W-1:0]      r_resBand;
    logic [COL_W-1:0]       r_resCol;
    logic [3*BIT_LEN-1:0]   r_buf [MAX_COLS];

    logic                   w_xfer;
    logic                   w_startOk;
    logic [IDX_W-1:0]       w_numColsExt;

    assign w_xfer       = s_valid & r_sReady;
    assign w_startOk    = (i_num_cols >= MIN_C) && (i_num_cols <= MAX_C) && (i_num_bands != '0);
    assign w_numColsExt = {1'b0, r_numCols};

    assign s_ready     = r_sReady;
    assign eng_rst     = r_engRst;
    assign eng_valid   = r_engValid;
    assign eng_sel_ki  = r_selKi;
    assign eng_d0      = r_engData[BIT_LEN-1:0];
    assign eng_d1      = r_engData[2*BIT_LEN-1:BIT_LEN];
    assign eng_d2      = r_engData[3*BIT_LEN-1:2*BIT_LEN];
    assign o_res_valid = r_resValid;
    assign o_res_band  = r_resBand;
    assign o_res_col   = r_resCol;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;

    // Column buffer: kernel uses entries 0..2, each band then reuses 0..N-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < MAX_COLS; k++) begin
                r_buf[k] <= '0;
            end
        end else if (w_xfer) begin
            r_buf[r_wrIdx[ADDR_W-1:0]] <= s_data;
        end
    end

    // Main sequencer. r_parity holds the parity of idle engine cycles seen so
    // far since the kernel burst; the cycle being decided in is itself idle,
    // so an image burst may start next cycle only when r_parity is 1.
    // Result tags travel through a 4-stage pipe plus the output register, so a
    // tag issued with push j appears four cycles after that push.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sReady    <= 1'b0;
            r_engRst    <= 1'b0;
            r_engValid  <= 1'b0;
            r_selKi     <= 1'b0;
            r_engData   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_numCols   <= '0;
            r_numBands  <= '0;
            r_band      <= '0;
            r_wrIdx     <= '0;
            r_idx       <= '0;
            r_parity    <= 1'b0;
            r_pipeValid <= '0;
            for (int k = 0; k < 4; k++) begin
                r_pipeBand[k] <= '0;
                r_pipeCol[k]  <= '0;
            end
            r_resValid  <= 1'b0;
            r_resBand   <= '0;
            r_resCol    <= '0;
        end else begin
            r_engRst    <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_parity    <= r_parity ^ ~r_engValid;
            r_pipeValid <= {r_pipeValid[2:0], 1'b0};
            for (int k = 1; k < 4; k++) begin
                r_pipeBand[k] <= r_pipeBand[k-1];
                r_pipeCol[k]  <= r_pipeCol[k-1];
            end
            r_resValid  <= r_pipeValid[3];
            r_resBand   <= r_pipeBand[3];
            r_resCol    <= r_pipeCol[3];

            unique case (r_state)
                IDLE: begin
                    if (i_start) begin
                        if (w_startOk) begin
                            r_numCols  <= i_num_cols;
                            r_numBands <= i_num_bands;
                            r_band     <= '0;
                            r_wrIdx    <= '0;
                            r_engRst   <= 1'b1;
                            r_busy     <= 1'b1;
                            r_sReady   <= 1'b1;
                            r_state    <= K_FILL;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end

                K_FILL: begin
                    if (w_xfer) begin
                        r_wrIdx <= r_wrIdx + COL_ONE;
                        if (r_wrIdx == COL_W'(2)) begin
                            r_sReady   <= 1'b0;
                            r_engValid <= 1'b1;
                            r_selKi    <= 1'b0;
                            r_engData  <= r_buf[0];
                            r_idx      <= IDX_ONE;
                            r_state    <= K_PUSH;
                        end
                    end
                end

                K_PUSH: begin
                    r_parity <= 1'b0;
                    if (r_idx < IDX_W'(3)) begin
                        r_engData <= r_buf[r_idx[ADDR_W-1:0]];
                        r_idx     <= r_idx + IDX_ONE;
                    end else begin
                        r_engValid <= 1'b0;
                        r_engData  <= '0;
                        r_sReady   <= 1'b1;
                        r_wrIdx    <= '0;
                        r_state    <= R_FILL;
                    end
                end

                R_FILL: begin
                    if (w_xfer) begin
                        r_wrIdx <= r_wrIdx + COL_ONE;
                        if (r_wrIdx == r_numCols - COL_ONE) begin
                            r_sReady <= 1'b0;
                            if (r_parity) begin
                                r_engValid <= 1'b1;
                                r_selKi    <= 1'b1;
                                r_engData  <= r_buf[0];
                                r_idx      <= IDX_ONE;
                                r_state    <= R_PUSH;
                            end else begin
                                r_state <= R_ALIGN;
                            end
                        end
                    end
                end

                R_ALIGN: begin
                    r_engValid <= 1'b1;
                    r_selKi    <= 1'b1;
                    r_engData  <= r_buf[0];
                    r_idx      <= IDX_ONE;
                    r_state    <= R_PUSH;
                end

                R_PUSH: begin
                    r_idx <= r_idx + IDX_ONE;
                    if (r_idx < w_numColsExt) begin
                        r_engData <= r_buf[r_idx[ADDR_W-1:0]];
                        if (r_idx >= IDX_W'(2)) begin
                            r_pipeValid[0] <= 1'b1;
                            r_pipeBand[0]  <= r_band;
                            r_pipeCol[0]   <= COL_W'(r_idx - IDX_W'(2));
                        end
                    end else begin
                        r_engData <= '0;
                        r_state   <= R_FLUSH;
                    end
                end

                R_FLUSH: begin
                    if (r_idx < w_numColsExt + IDX_W'(3)) begin
                        r_idx <= r_idx + IDX_ONE;
                    end else begin
                        r_engValid <= 1'b0;
                        r_selKi    <= 1'b0;
                        r_band     <= r_band + BAND_ONE;
                        if ((r_band + BAND_ONE) < r_numBands) begin
                            r_sReady <= 1'b1;
                            r_wrIdx  <= '0;
                            r_state  <= R_FILL;
                        end else begin
                            r_state <= DONE;
                        end
                    end
                end

                // One extra cycle so o_done lands after the final result strobe.
                DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_conv_seq_ctrl
// Randomized self-checking bench for conv_seq_ctrl. A behavioural engine
// (kernel registers that swap columns 1/2 on each idle cycle, a three-column
// sliding window) consumes the pushes; its results are compared against a
// golden convolution of the frame data computed directly from the arrays.
// ---------------------------------------------------------------------------
module tb_conv_seq_ctrl;

    localparam int BIT_LEN  = 8;
    localparam int MAX_COLS = 64;
    localparam int COL_W    = 7;
    localparam int BAND_W   = 10;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 i_start;
    logic [COL_W-1:0]     i_num_cols;
    logic [BAND_W-1:0]    i_num_bands;
    logic                 s_valid;
    logic [3*BIT_LEN-1:0] s_data;
    logic                 s_ready;
    logic                 eng_rst;
    logic                 eng_valid;
    logic                 eng_sel_ki;
    logic [BIT_LEN-1:0]   eng_d0, eng_d1, eng_d2;
    logic                 o_res_valid;
    logic [BAND_W-1:0]    o_res_band;
    logic [COL_W-1:0]     o_res_col;
    logic                 o_busy, o_done, o_err;

    always #5 clk = ~clk;

    conv_seq_ctrl #(.BIT_LEN(BIT_LEN), .MAX_COLS(MAX_COLS), .COL_W(COL_W), .BAND_W(BAND_W)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_num_cols(i_num_cols),
        .i_num_bands(i_num_bands), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .eng_rst(eng_rst), .eng_valid(eng_valid), .eng_sel_ki(eng_sel_ki),
        .eng_d0(eng_d0), .eng_d1(eng_d1), .eng_d2(eng_d2),
        .o_res_valid(o_res_valid), .o_res_band(o_res_band), .o_res_col(o_res_col),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    typedef struct { int band; int col; int value; } exp_t;
    typedef struct { int due; int value; } tim_t;

    int          assertCount = 0;
    int          failCount   = 0;
    logic [23:0] kern [3];
    logic [23:0] img  [4][MAX_COLS];
    int          curN = 3, curBands = 1, validProb = 100;
    exp_t        expQ[$];
    tim_t        tq[$];
    logic [23:0] srcQ[$];

    int          cyc = 0, tfr = 0, kidx = 0, band = 0, jIdx = 0;
    int          strobeCount = 0, engRstCount = 0;
    bit          inBurst = 0, swapPar = 0;
    logic [23:0] kcol [3];
    logic [23:0] win  [3];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int conv3(input logic [23:0] k0, k1, k2, w0, w1, w2);
        int s = 0;
        for (int r = 0; r < 3; r++) begin
            s += int'(k0[r*8 +: 8]) * int'(w0[r*8 +: 8])
               + int'(k1[r*8 +: 8]) * int'(w1[r*8 +: 8])
               + int'(k2[r*8 +: 8]) * int'(w2[r*8 +: 8]);
        end
        return s;
    endfunction

    // Upstream source: presents the head of srcQ with random valid.
    initial begin
        logic xfer;
        s_valid = 1'b0;
        s_data  = '0;
        forever begin
            @(negedge clk);
            xfer = s_valid && s_ready;
            @(posedge clk);
            #1;
            if (xfer && srcQ.size() > 0) void'(srcQ.pop_front());
            if (srcQ.size() > 0 && $urandom_range(99) < validProb) begin
                s_valid = 1'b1;
                s_data  = srcQ[0];
            end else begin
                s_valid = 1'b0;
                s_data  = '0;
            end
        end
    end

    // Behavioural engine and result monitor.
    always @(negedge clk) begin
        logic [23:0] d;
        tim_t        t;
        exp_t        e;
        logic [23:0] tmp;
        cyc++;
        d = {eng_d2, eng_d1, eng_d0};
        if (rst) begin
            tq.delete();
            inBurst = 0;
        end else begin
            if (eng_rst) begin
                engRstCount++;
                kidx = 0; band = 0; jIdx = 0; tfr = 0;
                inBurst = 0; swapPar = 0;
                for (int k = 0; k < 3; k++) begin kcol[k] = '0; win[k] = '0; end
            end
            if (s_valid && s_ready) tfr++;
            checkOutput("readyInPush", {31'd0, s_ready && eng_valid}, 0);
            if (!eng_valid) checkOutput("dataIdle", {8'd0, d}, 0);

            if (eng_valid && !eng_sel_ki) begin
                if (kidx < 3) begin
                    checkOutput("kernData", {8'd0, d}, {8'd0, kern[kidx]});
                    kcol[kidx] = d;
                end else begin
                    checkOutput("kernCount", kidx, 2);
                end
                kidx++;
                swapPar = 0;
            end else if (eng_valid && eng_sel_ki) begin
                if (!inBurst) begin
                    checkOutput("parity", {31'd0, swapPar}, 0);
                    checkOutput("fillBeats", tfr, 3 + (band + 1) * curN);
                    inBurst = 1;
                    jIdx = 0;
                end
                checkOutput("pushData", {8'd0, d},
                            (jIdx < curN && band < curBands && band < 4) ? {8'd0, img[band][jIdx]} : 32'd0);
                win[0] = win[1]; win[1] = win[2]; win[2] = d;
                if (jIdx >= 2 && jIdx <= curN - 1) begin
                    t.due   = cyc + 4;
                    t.value = conv3(kcol[0], kcol[1], kcol[2], win[0], win[1], win[2]);
                    tq.push_back(t);
                end
                jIdx++;
            end else begin
                swapPar = ~swapPar;
                tmp = kcol[1]; kcol[1] = kcol[2]; kcol[2] = tmp;
                if (inBurst) begin
                    checkOutput("burstLen", jIdx, curN + 3);
                    inBurst = 0;
                    band++;
                end
            end

            if (o_res_valid) begin
                strobeCount++;
                if (tq.size() == 0) begin
                    checkOutput("spuriousStrobe", {31'd0, o_res_valid}, 0);
                end else begin
                    t = tq.pop_front();
                    checkOutput("strobeCycle", cyc, t.due);
                    if (expQ.size() > 0) begin
                        e = expQ.pop_front();
                        checkOutput("resBand", {22'd0, o_res_band}, e.band);
                        checkOutput("resCol", {25'd0, o_res_col}, e.col);
                        checkOutput("resValue", t.value, e.value);
                    end else begin
                        checkOutput("extraResult", {31'd0, o_res_valid}, 0);
                    end
                end
            end else if (tq.size() > 0 && tq[0].due <= cyc) begin
                checkOutput("missingStrobe", {31'd0, o_res_valid}, 1);
                void'(tq.pop_front());
                if (expQ.size() > 0) void'(expQ.pop_front());
            end
        end
    end

    task automatic pulseStart(input int n, input int bands);
        @(posedge clk);
        #1;
        i_start     = 1'b1;
        i_num_cols  = COL_W'(n);
        i_num_bands = BAND_W'(bands);
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    // Builds frame data and golden results, queues the stream, starts the frame.
    task automatic applyStimulus(input int n, input int bands, input int prob, input bit centerPattern);
        exp_t e;
        validProb = prob;
        curN      = n;
        curBands  = bands;
        if (centerPattern) begin
            kern[0] = '0; kern[1] = 24'h000100; kern[2] = '0;
        end else begin
            do begin
                for (int k = 0; k < 3; k++) kern[k] = 24'($urandom);
            end while (kern[1] == kern[2]);
        end
        for (int b = 0; b < bands; b++) begin
            for (int j = 0; j < n; j++) begin
                img[b][j] = centerPattern ? {3{8'(j + 1)}} : 24'($urandom);
            end
        end
        expQ.delete();
        for (int b = 0; b < bands; b++) begin
            for (int c = 0; c <= n - 3; c++) begin
                e.band  = b;
                e.col   = c;
                e.value = conv3(kern[0], kern[1], kern[2], img[b][c], img[b][c+1], img[b][c+2]);
                expQ.push_back(e);
            end
        end
        srcQ.delete();
        for (int k = 0; k < 3; k++) srcQ.push_back(kern[k]);
        for (int b = 0; b < bands; b++) begin
            for (int j = 0; j < n; j++) srcQ.push_back(img[b][j]);
        end
        strobeCount = 0;
        engRstCount = 0;
        pulseStart(n, bands);
        @(negedge clk);
        checkOutput("busyAfterStart", {31'd0, o_busy}, 1);
        checkOutput("engRstPulse", {31'd0, eng_rst}, 1);
    endtask

    task automatic waitDone();
        int cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!o_done && cnt < 20000);
        if (!o_done) begin
            checkOutput("doneTimeout", {31'd0, o_done}, 1);
        end else begin
            checkOutput("busyAtDone", {31'd0, o_busy}, 0);
            checkOutput("pendingTimed", tq.size(), 0);
            checkOutput("pendingResults", expQ.size(), 0);
            checkOutput("strobeCount", strobeCount, curBands * (curN - 2));
            checkOutput("engRstCount", engRstCount, 1);
            @(negedge clk);
            checkOutput("donePulse", {31'd0, o_done}, 0);
        end
    endtask

    task automatic applyBadStart(input int n, input int bands);
        pulseStart(n, bands);
        @(negedge clk);
        checkOutput("errPulse", {31'd0, o_err}, 1);
        checkOutput("errReady", {31'd0, s_ready}, 0);
        checkOutput("errBusy", {31'd0, o_busy}, 0);
        @(negedge clk);
        checkOutput("errCleared", {31'd0, o_err}, 0);
        checkOutput("errIdle", {31'd0, eng_rst}, 0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ready"}, {31'd0, s_ready}, 0);
        checkOutput({tag, "_engRst"}, {31'd0, eng_rst}, 0);
        checkOutput({tag, "_engValid"}, {31'd0, eng_valid}, 0);
        checkOutput({tag, "_selKi"}, {31'd0, eng_sel_ki}, 0);
        checkOutput({tag, "_engData"}, {8'd0, eng_d2, eng_d1, eng_d0}, 0);
        checkOutput({tag, "_res"}, {14'd0, o_res_valid, o_res_band, o_res_col}, 0);
        checkOutput({tag, "_status"}, {29'd0, o_busy, o_done, o_err}, 0);
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        i_start = 1'b0;
        i_num_cols = '0;
        i_num_bands = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] centre kernel, N=5, one band, always-valid source");
        applyStimulus(5, 1, 100, 1'b1);
        waitDone();

        $display("[TB] random frames with gappy source");
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                applyStimulus(10, 2, 50, 1'b0);
                repeat (8) @(posedge clk);
                @(negedge clk);
                checkOutput("busyMidFrame", {31'd0, o_busy}, 1);
                pulseStart(3, 1);
                @(negedge clk);
                checkOutput("startIgnoredErr", {31'd0, o_err}, 0);
                checkOutput("startIgnoredRst", {31'd0, eng_rst}, 0);
            end else begin
                applyStimulus($urandom_range(3, 12), $urandom_range(1, 3), 50, 1'b0);
            end
            waitDone();
        end

        $display("[TB] rejected starts");
        applyBadStart(2, 1);
        applyBadStart(MAX_COLS + 1, 1);
        applyBadStart(6, 0);

        $display("[TB] reset during image burst");
        applyStimulus(8, 2, 60, 1'b0);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!(eng_valid && eng_sel_ki) && cnt < 2000);
        checkOutput("pushSeen", {31'd0, eng_valid && eng_sel_ki}, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkAllZero("midReset");
        srcQ.delete();
        expQ.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(6, 1, 70, 1'b0);
        waitDone();

        $display("[TB] two bands at maximum width");
        applyStimulus(MAX_COLS, 2, 80, 1'b0);
        waitDone();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
